// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_cmd_pkg                                                |
// | Description : Shared types and constants for the uart_cmd_rx front end.   |
// |               Receiver FSM state encoding, oversampling constants and     |
// |               the failsafe command byte.                                  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int         OVERSAMPLE    = 16;
  localparam logic [3:0] MID_SAMPLE    = 4'd7;
  // Last oversample tick of a bit period; bit boundaries are taken here.
  localparam logic [3:0] LAST_SAMPLE   = 4'(OVERSAMPLE - 1);
  localparam int         SERVO_SEL_BIT = 7;
  localparam logic [7:0] FAILSAFE_CMD  = 8'h00;

  // A motor command is any byte whose target-select bit is clear.
  function automatic logic is_motor_cmd(input logic [7:0] cmd);
    return ~cmd[SERVO_SEL_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : uart_cmd_rx_if                                              |
// | Description : Serial line in, command byte and status strobes out.        |
// |   rx_serial    1  UART line, idles high (driven by master)               |
// |   control_val  8  last accepted command byte                             |
// |   data_ready   1  one-cycle strobe, control_val is new                    |
// |   frame_err    1  one-cycle strobe, stop bit sampled low                  |
// |   rx_busy      1  receiver FSM not idle                                   |
// |   modport master : host/line side;  modport slave : receiver side        |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface uart_cmd_rx_if;
  logic       rx_serial;
  logic [7:0] control_val;
  logic       data_ready;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_serial,
    input  control_val,
    input  data_ready,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_serial,
    output control_val,
    output data_ready,
    output frame_err,
    output rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : baud_tick_gen                                               |
// | Description : Free-running divider producing one os_tick every DIV clk    |
// |               cycles (16x the line rate). With DIV=1 the tick is high     |
// |               every cycle.                                                |
// |   clk      in   system clock                                             |
// |   clr      in   asynchronous active-low reset, count returns to 0        |
// |   os_tick  out  oversample strobe                                        |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clr,
  output logic os_tick
);

  // A one-bit counter is kept for DIV=1 so the structure is uniform; it
  // simply stays at zero and the terminal compare is always true.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign os_tick = (r_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_rx                                                 |
// | Description : 8N1 UART command receiver with 16x oversampling. Each good  |
// |               byte is presented on control_val with a one-cycle           |
// |               data_ready strobe; a low stop bit gives one frame_err.      |
// |               control_val[7]: 1 = servo target, 0 = motor target.         |
// |   clk   in   system clock                                                |
// |   clr   in   asynchronous active-low reset                               |
// |   bus   slave modport of uart_cmd_rx_if (rx_serial in; control_val,     |
// |         data_ready, frame_err, rx_busy out)                              |
// | Config      : define UART_FAILSAFE_EN to add the silent-host watchdog,    |
// |               which re-issues FAILSAFE_CMD after TIMEOUT_CYCLES without   |
// |               a motor byte.                                               |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BAUD           = 115_200,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              clr,
  uart_cmd_rx_if.slave      bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

  if (DIV < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_cmd_rx: CLK_HZ/(BAUD*16) must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  // ------------------------------------------------------------------------
  // Line synchroniser; both stages preset to the idle (high) level.
  // ------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // ------------------------------------------------------------------------
  // Oversample tick
  // ------------------------------------------------------------------------
  logic w_os_tick;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .clr     (clr),
    .os_tick (w_os_tick)
  );

  // ------------------------------------------------------------------------
  // Receiver FSM
  //   Each state is entered on a bit boundary with os_cnt=0, so MID_SAMPLE
  //   is the bit centre and LAST_SAMPLE the end of the bit. START rejects
  //   glitches at its centre but runs to the end of the start bit before
  //   DATA; DATA likewise finishes bit 7 before STOP. STOP decides at the
  //   stop-bit centre and returns to IDLE there, leaving half a bit of
  //   margin to catch a following start edge with no idle gap.
  // ------------------------------------------------------------------------
  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_os_cnt;
  logic [3:0] w_os_cnt_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       w_mid;
  logic       w_end;
  logic       w_byte_ok;
  logic       w_frame_bad;

  assign w_mid = w_os_tick && (r_os_cnt == MID_SAMPLE);
  assign w_end = w_os_tick && (r_os_cnt == LAST_SAMPLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_os_cnt_nxt  = r_os_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_byte_ok     = 1'b0;
    w_frame_bad   = 1'b0;

    if (w_os_tick) begin
      w_os_cnt_nxt = r_os_cnt + 4'd1;
    end

    case (r_state)
      IDLE: begin
        w_os_cnt_nxt  = '0;
        w_bit_cnt_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_mid && w_rxs) begin
          w_state_nxt  = IDLE;
          w_os_cnt_nxt = '0;
        end else if (w_end) begin
          w_state_nxt   = DATA;
          w_os_cnt_nxt  = '0;
          w_bit_cnt_nxt = '0;
        end
      end

      DATA: begin
        if (w_mid) begin
          w_shift_nxt = {w_rxs, r_shift[7:1]};
        end
        if (w_end) begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt  = STOP;
            w_os_cnt_nxt = '0;
          end
        end
      end

      STOP: begin
        if (w_mid) begin
          w_os_cnt_nxt = '0;
          if (w_rxs) begin
            w_byte_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end

      BREAK: begin
        // Wait out a held-low line so it reports only one frame error.
        w_os_cnt_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_os_cnt_nxt = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Optional silent-host watchdog
  // ------------------------------------------------------------------------
  logic w_wd_fire;

`ifdef UART_FAILSAFE_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;

  assign w_wd_fire = (r_wd_cnt == WD_LAST);

  // Only motor bytes prove the host is alive for the motor; servo traffic
  // alone does not hold off the stop command.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wd_cnt <= '0;
    end else if ((w_byte_ok && is_motor_cmd(r_shift)) || w_wd_fire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Output registers. A received byte takes priority over the failsafe.
  // ------------------------------------------------------------------------
  logic [7:0] r_control_val;
  logic       r_data_ready;
  logic       r_frame_err;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_control_val <= '0;
      r_data_ready  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_data_ready <= 1'b0;
      r_frame_err  <= w_frame_bad;
      if (w_byte_ok) begin
        r_control_val <= r_shift;
        r_data_ready  <= 1'b1;
      end else if (w_wd_fire) begin
        r_control_val <= FAILSAFE_CMD;
        r_data_ready  <= 1'b1;
      end
    end
  end

  assign bus.control_val = r_control_val;
  assign bus.data_ready  = r_data_ready;
  assign bus.frame_err   = r_frame_err;
  assign bus.rx_busy     = (r_state != IDLE);

endmodule
`default_nettype wire
